// File: rtl/pcm_frame_sched.sv
// pcm_frame_sched: sequencer for the I2S PCM test generator.
// Divides scki into bck, generates lrck, time-shares the sine-LUT read port
// between the left and right phase accumulators, and strobes load/shift for
// the output shift register.
// Optional feature macro: PCM_SEQ_STATUS_EN adds the o_frame_cnt status port.
module pcm_frame_sched #(
  parameter int BCK_DIV   = 4,
  parameter int SLOT_BITS = 32,
  parameter int DATA_BITS = 24,
  parameter int ADDR_W    = 12
) (
  input  logic              scki,
  input  logic              rst,
  input  logic              i_enable,
  input  logic [ADDR_W-1:0] i_step_l,
  input  logic [ADDR_W-1:0] i_step_r,
  output logic              o_bck,
  output logic              o_lrck,
  output logic [ADDR_W-1:0] o_lut_addr,
  output logic              o_lut_rd,
  output logic              o_load,
  output logic              o_shift,
  output logic              o_busy
`ifdef PCM_SEQ_STATUS_EN
  ,
  output logic [15:0]       o_frame_cnt
`endif
);

  // The bit counter must hold a full slot; a slot is always wider than a sample.
  localparam int CNT_MAX = (SLOT_BITS > DATA_BITS) ? SLOT_BITS : (DATA_BITS + 1);
  localparam int BIT_W   = $clog2(CNT_MAX);
  localparam int DIV_W   = $clog2(BCK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(BCK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(SLOT_BITS - 1);
  // Read is registered on the tick before the mid-slot bit, so it is visible at SLOT_BITS/2.
  localparam logic [BIT_W-1:0] BIT_PRE_RD = BIT_W'(SLOT_BITS / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREFETCH = 2'd1,
    S_RUN      = 2'd2,
    S_DRAIN    = 2'd3
  } state_t;

  state_t            r_state, w_state;
  logic              r_pre, w_pre;
  logic [DIV_W-1:0]  r_div, w_div;
  logic [BIT_W-1:0]  r_bit, w_bit;
  logic              r_bck;
  logic              r_lrck, w_lrck;
  logic [ADDR_W-1:0] r_lut_addr, w_lut_addr;
  logic              r_lut_rd, w_lut_rd;
  logic              r_rd_is_r, w_rd_is_r;
  logic              r_load, w_load;
  logic              r_shift, w_shift;
  logic              r_busy;
  logic [ADDR_W-1:0] r_phase_l, w_phase_l;
  logic [ADDR_W-1:0] r_phase_r, w_phase_r;
  logic [ADDR_W-1:0] r_step_l, w_step_l;
  logic [ADDR_W-1:0] r_step_r, w_step_r;
  logic              w_tick;

  assign w_tick = (r_div == DIV_LAST);

  // Next-state, counter, strobe and phase-accumulator logic.
  always_comb begin
    w_state    = r_state;
    w_pre      = r_pre;
    w_div      = r_div;
    w_bit      = r_bit;
    w_lrck     = r_lrck;
    w_lut_addr = r_lut_addr;
    w_lut_rd   = 1'b0;
    w_rd_is_r  = r_rd_is_r;
    w_load     = 1'b0;
    w_shift    = 1'b0;
    w_phase_l  = r_phase_l;
    w_phase_r  = r_phase_r;
    w_step_l   = r_step_l;
    w_step_r   = r_step_r;

    // The accumulator of the channel just read advances one cycle after its read.
    if (r_lut_rd && r_rd_is_r) begin
      w_phase_r = r_phase_r + r_step_r;
    end else if (r_lut_rd) begin
      w_phase_l = r_phase_l + r_step_l;
    end else begin
      w_phase_l = r_phase_l;
    end

    case (r_state)
      S_IDLE: begin
        w_div  = '0;
        w_bit  = '0;
        w_lrck = 1'b1;
        w_pre  = 1'b0;
        if (i_enable) begin
          // First frame: fetch the left sample now and latch this frame's steps.
          w_state    = S_PREFETCH;
          w_lut_rd   = 1'b1;
          w_lut_addr = r_phase_l;
          w_rd_is_r  = 1'b0;
          w_step_l   = i_step_l;
          w_step_r   = i_step_r;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_PREFETCH: begin
        if (!r_pre) begin
          w_pre  = 1'b1;
          w_load = 1'b1;
        end else begin
          w_pre   = 1'b0;
          w_state = S_RUN;
          w_lrck  = 1'b0;
          w_bit   = '0;
          w_div   = '0;
        end
      end
      S_RUN, S_DRAIN: begin
        if ((r_state == S_RUN) && !i_enable) begin
          w_state = S_DRAIN;
        end else begin
          w_state = r_state;
        end
        if (w_tick) begin
          w_div = '0;
          if (r_bit == BIT_LAST) begin
            w_bit = '0;
            if (!r_lrck) begin
              w_lrck = 1'b1;
              w_load = 1'b1;
            end else if (r_state == S_DRAIN) begin
              // Right slot finished while draining: stop cleanly with lrck high.
              w_state = S_IDLE;
              w_lrck  = 1'b1;
            end else begin
              // New stereo frame: steps sampled here apply to this frame's updates.
              w_lrck   = 1'b0;
              w_load   = 1'b1;
              w_step_l = i_step_l;
              w_step_r = i_step_r;
            end
          end else begin
            w_bit   = r_bit + BIT_W'(1);
            w_shift = 1'b1;
            if ((r_bit == BIT_PRE_RD) && (r_state == S_RUN) && i_enable) begin
              // Fetch the opposite channel's next sample well ahead of its load.
              w_lut_rd   = 1'b1;
              w_rd_is_r  = !r_lrck;
              w_lut_addr = r_lrck ? r_phase_l : r_phase_r;
            end else begin
              w_lut_rd = 1'b0;
            end
          end
        end else begin
          w_div = r_div + DIV_W'(1);
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge scki) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pre      <= 1'b0;
      r_div      <= '0;
      r_bit      <= '0;
      r_bck      <= 1'b0;
      r_lrck     <= 1'b1;
      r_lut_addr <= '0;
      r_lut_rd   <= 1'b0;
      r_rd_is_r  <= 1'b0;
      r_load     <= 1'b0;
      r_shift    <= 1'b0;
      r_busy     <= 1'b0;
      r_phase_l  <= '0;
      r_phase_r  <= '0;
      r_step_l   <= '0;
      r_step_r   <= '0;
    end else begin
      r_state    <= w_state;
      r_pre      <= w_pre;
      r_div      <= w_div;
      r_bit      <= w_bit;
      r_bck      <= (w_div >= DIV_HALF);
      r_lrck     <= w_lrck;
      r_lut_addr <= w_lut_addr;
      r_lut_rd   <= w_lut_rd;
      r_rd_is_r  <= w_rd_is_r;
      r_load     <= w_load;
      r_shift    <= w_shift;
      r_busy     <= (w_state != S_IDLE);
      r_phase_l  <= w_phase_l;
      r_phase_r  <= w_phase_r;
      r_step_l   <= w_step_l;
      r_step_r   <= w_step_r;
    end
  end

  assign o_bck      = r_bck;
  assign o_lrck     = r_lrck;
  assign o_lut_addr = r_lut_addr;
  assign o_lut_rd   = r_lut_rd;
  assign o_load     = r_load;
  assign o_shift    = r_shift;
  assign o_busy     = r_busy;

`ifdef PCM_SEQ_STATUS_EN
  logic [15:0] r_frame_cnt;
  logic        w_frame_end;

  assign w_frame_end = ((r_state == S_RUN) || (r_state == S_DRAIN)) && w_tick &&
                       (r_bit == BIT_LAST) && r_lrck;

  // Count completed stereo frames; wraps naturally at 16 bits.
  always_ff @(posedge scki) begin
    if (rst) begin
      r_frame_cnt <= 16'd0;
    end else if (w_frame_end) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end else begin
      r_frame_cnt <= r_frame_cnt;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_pcm_frame_sched.sv
// Bench for pcm_frame_sched (BCK_DIV=4, SLOT_BITS=32, ADDR_W=12).
// Reference model predicts every output from the cycle index since start:
// 2 prefetch cycles, then k-indexed run cycles (bck=4, slot=128, frame=256).
module tb_pcm_frame_sched;

  logic        scki = 1'b0;
  logic        rst;
  logic        i_enable;
  logic [11:0] i_step_l;
  logic [11:0] i_step_r;
  logic        o_bck, o_lrck, o_lut_rd, o_load, o_shift, o_busy;
  logic [11:0] o_lut_addr;
`ifdef PCM_SEQ_STATUS_EN
  logic [15:0] o_frame_cnt;
`endif

  pcm_frame_sched #(
    .BCK_DIV(4), .SLOT_BITS(32), .DATA_BITS(24), .ADDR_W(12)
  ) u_dut (
    .scki(scki), .rst(rst), .i_enable(i_enable),
    .i_step_l(i_step_l), .i_step_r(i_step_r),
    .o_bck(o_bck), .o_lrck(o_lrck), .o_lut_addr(o_lut_addr), .o_lut_rd(o_lut_rd),
    .o_load(o_load), .o_shift(o_shift), .o_busy(o_busy)
`ifdef PCM_SEQ_STATUS_EN
    , .o_frame_cnt(o_frame_cnt)
`endif
  );

  always #5 scki = ~scki;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model state
  logic        m_act = 1'b0;
  logic        m_drain = 1'b0;
  logic        m_rst_last = 1'b0;
  int          m_n = 0;
  int          m_kend = 0;
  int          m_fc = 0;
  logic [11:0] m_ph_l = 12'h000;
  logic [11:0] m_ph_r = 12'h000;
  logic [11:0] m_st_l = 12'h000;
  logic [11:0] m_st_r = 12'h000;

  // observation records for directed checks
  logic [11:0] rdq[$];
  int          lrck_rise[$];
  int          load_at[$];
  int          shq[$];
  int          sh_cnt = 0;
  logic        p_lrck = 1'b1;

  logic [11:0] exp2[6] = '{12'h000, 12'h000, 12'h001, 12'h002, 12'h002, 12'h004};
  logic [11:0] exp3[6] = '{12'h000, 12'h000, 12'h800, 12'hFFF, 12'h000, 12'hFFE};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // One scki cycle: advance the model across the edge, then compare all outputs.
  task automatic tick();
    int          kp, k, dv, bp;
    logic        e_rd, e_load, e_shift, e_bck, e_lrck, ch_r;
    logic [11:0] e_addr;
    m_rst_last = rst;
    if (rst) begin
      m_act = 1'b0; m_ph_l = 12'h000; m_ph_r = 12'h000; m_fc = 0;
    end else if (!m_act) begin
      if (i_enable) begin
        m_act = 1'b1; m_n = 0; m_drain = 1'b0; m_st_l = i_step_l; m_st_r = i_step_r;
      end
    end else begin
      kp = m_n - 2;
      if (kp >= 0 && !m_drain && !i_enable) begin
        m_drain = 1'b1;
        m_kend  = ((kp + 1) / 256 + 1) * 256;
      end
      m_n++;
      k = m_n - 2;
      if (k > 0 && (k % 256) == 0) begin
        m_fc++;
        if (m_drain && k == m_kend) m_act = 1'b0;
        else begin m_st_l = i_step_l; m_st_r = i_step_r; end
      end
    end
    @(posedge scki);
    #1;
    cyc++;
    e_rd = 1'b0; e_load = 1'b0; e_shift = 1'b0; e_bck = 1'b0; e_lrck = 1'b1;
    ch_r = 1'b0; e_addr = 12'h000;
    if (m_act) begin
      if (m_n == 0) e_rd = 1'b1;
      else if (m_n == 1) e_load = 1'b1;
      else begin
        k  = m_n - 2;
        dv = k % 4;
        bp = (k / 4) % 32;
        e_lrck  = ((k / 128) % 2) == 1;
        e_bck   = (dv >= 2);
        e_load  = (dv == 0) && (bp == 0) && (k > 0);
        e_shift = (dv == 0) && (bp != 0);
        if (dv == 0 && bp == 16 && !m_drain) begin
          e_rd = 1'b1;
          ch_r = !e_lrck;
        end
      end
      if (e_rd) begin
        e_addr = ch_r ? m_ph_r : m_ph_l;
        if (ch_r) m_ph_r = m_ph_r + m_st_r;
        else      m_ph_l = m_ph_l + m_st_l;
      end
    end
    chk("busy", o_busy, m_act);
    chk("bck", o_bck, e_bck);
    chk("lrck", o_lrck, e_lrck);
    chk("lut_rd", o_lut_rd, e_rd);
    chk("load", o_load, e_load);
    chk("shift", o_shift, e_shift);
    if (e_rd) chk("lut_addr", o_lut_addr, e_addr);
    if (m_rst_last) chk("addr_rst", o_lut_addr, 32'h0);
`ifdef PCM_SEQ_STATUS_EN
    chk("frame_cnt", o_frame_cnt, m_fc & 32'hFFFF);
`endif
    if (o_lut_rd) rdq.push_back(o_lut_addr);
    if (o_lrck && !p_lrck) lrck_rise.push_back(cyc);
    p_lrck = o_lrck;
    if (o_shift) sh_cnt++;
    if (o_load) begin
      load_at.push_back(cyc);
      shq.push_back(sh_cnt);
      sh_cnt = 0;
    end
  endtask

  // Advance until the run is at frame offset ph (0..255); bounded.
  task automatic adv_to_phase(input int ph);
    int w = 0;
    while (!(m_act && m_n >= 2 && ((m_n - 2) % 256) == ph) && w < 1200) begin
      tick();
      w++;
    end
    chk("adv_bound", (w < 1200), 1);
  endtask

  // Wait for the drain to finish; bounded.
  task automatic wait_idle(input string tag);
    int w = 0;
    while (o_busy && w < 700) begin
      tick();
      w++;
    end
    chk(tag, o_busy, 1'b0);
  endtask

  initial begin
    // 1: reset held with enable high
    rst = 1'b1; i_enable = 1'b1; i_step_l = 12'h001; i_step_r = 12'h002;
    repeat (10) tick();

    // 2: steps 1/2, three frames
    rst = 1'b0;
    rdq.delete(); lrck_rise.delete(); load_at.delete(); shq.delete(); sh_cnt = 0;
    repeat (2 + 3 * 256) tick();
    for (int i = 0; i < 6; i++)
      chk($sformatf("t2_addr%0d", i), (rdq.size() > i) ? 32'(rdq[i]) : 32'hFFFF_FFFF, 32'(exp2[i]));
    chk("t2_lrck_period", (lrck_rise.size() >= 2) ? (lrck_rise[1] - lrck_rise[0]) : -1, 256);
    chk("t2_load_gap", (load_at.size() >= 3) ? (load_at[2] - load_at[1]) : -1, 128);
    chk("t2_shifts_a", (shq.size() >= 3) ? shq[1] : -1, 31);
    chk("t2_shifts_b", (shq.size() >= 3) ? shq[2] : -1, 31);

    // 5: enable drop mid left slot
    adv_to_phase($urandom_range(10, 120));
    i_enable = 1'b0;
    rdq.delete();
    wait_idle("t5_drain_done");
    chk("t5_no_rd", rdq.size(), 0);
    chk("t5_lrck", o_lrck, 1'b1);
    chk("t5_bck", o_bck, 1'b0);

    // 3: wrap-around steps from phase 0
    rst = 1'b1;
    tick();
    rst = 1'b0; i_enable = 1'b1; i_step_l = 12'h800; i_step_r = 12'hFFF;
    rdq.delete();
    repeat (600) tick();
    for (int i = 0; i < 6; i++)
      chk($sformatf("t3_addr%0d", i), (rdq.size() > i) ? 32'(rdq[i]) : 32'hFFFF_FFFF, 32'(exp3[i]));

    // 4: step_l change mid right slot
    adv_to_phase(128 + $urandom_range(1, 50));
    i_step_l = 12'($urandom);
    repeat (800) tick();

    // random sessions: step changes, drops at any point, re-enable during drain
    for (int it = 0; it < 6; it++) begin
      i_step_l = 12'($urandom); i_step_r = 12'($urandom); i_enable = 1'b1;
      repeat ($urandom_range(100, 900)) tick();
      i_step_l = 12'($urandom);
      repeat ($urandom_range(50, 400)) tick();
      i_enable = 1'b0;
      repeat ($urandom_range(5, 100)) tick();
      if (it % 2 == 1) i_enable = 1'b1;
      repeat ($urandom_range(50, 700)) tick();
    end

    // 6: reset mid right slot, restart from phase 0
    i_enable = 1'b1;
    adv_to_phase(128 + $urandom_range(10, 100));
    rst = 1'b1;
    tick();
    chk("t6_busy", o_busy, 1'b0);
    chk("t6_lrck", o_lrck, 1'b1);
`ifdef PCM_SEQ_STATUS_EN
    chk("t6_fc_reset", o_frame_cnt, 32'h0);
`endif
    rst = 1'b0; i_step_l = 12'h001; i_step_r = 12'h001;
    tick();
    chk("t6_restart_rd", o_lut_rd, 1'b1);
    chk("t6_restart_addr", o_lut_addr, 32'h0);
    repeat (770) tick();
`ifdef PCM_SEQ_STATUS_EN
    chk("t6_fc_three", o_frame_cnt, 32'd3);
`endif
    i_enable = 1'b0;
    wait_idle("t6_drain_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
